// File: rtl/block_serializer.sv
// block_serializer: parallel-to-serial transmitter.
// A WIDTH-bit block is taken over a load valid/ready handshake and is then
// shifted out one bit per accepted serial cycle, MSB- or LSB-first.
// Ports:
//   clk, clear_b             clock, asynchronous active-low reset
//   load_valid/load_ready    parallel-side handshake
//   parallel_in, lsb_first   block and bit order, sampled at load
//   serial_ready             sink accepts the current bit
//   serial_out/serial_valid  current bit and its qualifier
//   frame_start/frame_end    first / last bit of a frame
//   busy                     frame in progress
//   bit_count                index of the current bit within the frame
module block_serializer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             lsb_first,
    input  logic             serial_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic             r_lsb;
    logic [CNT_W-1:0] r_cnt;

    logic w_shift;
    logic w_last;
    logic w_xfer;
    logic w_load;

    // Handshake decode; load_ready opens in the last transfer cycle so
    // frames can follow each other with no idle cycle.
    assign w_shift    = (r_state == SHIFT);
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_xfer     = w_shift & serial_ready;
    assign load_ready = clear_b & (~w_shift | (w_xfer & w_last));
    assign w_load     = load_valid & load_ready;

    // Serial-side outputs decoded from the registered state
    assign serial_out   = w_shift & (r_lsb ? r_sr[0] : r_sr[WIDTH-1]);
    assign serial_valid = w_shift;
    assign busy         = w_shift;
    assign frame_start  = w_shift & (r_cnt == '0);
    assign frame_end    = w_shift & w_last;
    assign bit_count    = r_cnt;

    // Frame FSM with shift register and bit counter
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_lsb   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_state <= SHIFT;
            r_sr    <= parallel_in;
            r_lsb   <= lsb_first;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_state <= IDLE;
                r_sr    <= '0;
                r_cnt   <= '0;
            end else begin
                r_sr  <= r_lsb ? (r_sr >> 1) : (r_sr << 1);
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_block_serializer.sv
module tb_block_serializer;

    logic clk = 1'b0;
    logic clear_b;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       lv4, lr4, lsb4, srdy4, so4, sv4, fs4, fe4, bz4;
    logic [3:0] pin4;
    logic [1:0] cnt4;

    block_serializer #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .clear_b(clear_b),
        .load_valid(lv4), .load_ready(lr4), .parallel_in(pin4), .lsb_first(lsb4),
        .serial_ready(srdy4), .serial_out(so4), .serial_valid(sv4),
        .frame_start(fs4), .frame_end(fe4), .busy(bz4), .bit_count(cnt4)
    );

    // 64-bit instance with default parameters
    logic        lv64, lr64, lsb64, srdy64, so64, sv64, fs64, fe64, bz64;
    logic [63:0] pin64;
    logic [5:0]  cnt64;

    block_serializer dut64 (
        .clk(clk), .clear_b(clear_b),
        .load_valid(lv64), .load_ready(lr64), .parallel_in(pin64), .lsb_first(lsb64),
        .serial_ready(srdy64), .serial_out(so64), .serial_valid(sv64),
        .frame_start(fs64), .frame_end(fe64), .busy(bz64), .bit_count(cnt64)
    );

    int checks   = 0;
    int failures = 0;

    // expected = {load_ready, serial_out, serial_valid, frame_start, frame_end, busy, bit_count}
    typedef struct {
        logic       lv;
        logic [3:0] pin;
        logic       lsb;
        logic       srdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic q4[$];
    logic q64[$];

    function automatic vec_t mk(input logic lv, input logic [3:0] pin, input logic lsb,
                                input logic srdy, input logic lr, input logic so,
                                input logic sv, input logic fs, input logic fe,
                                input logic [1:0] c);
        vec_t t;
        t.lv   = lv;
        t.pin  = pin;
        t.lsb  = lsb;
        t.srdy = srdy;
        t.exp  = {lr, so, sv, fs, fe, sv, c};
        return t;
    endfunction

    // Apply one cycle of stimulus, compare outputs, run the bit scoreboard
    task automatic step4(input vec_t t, input int idx);
        logic [7:0] got;
        logic       b;
        @(negedge clk);
        lv4   = t.lv;
        pin4  = t.pin;
        lsb4  = t.lsb;
        srdy4 = t.srdy;
        #1;
        got = {lr4, so4, sv4, fs4, fe4, bz4, cnt4};
        checks++;
        if (got !== t.exp) begin
            failures++;
            $display("FAIL vec[%0d] outputs got=%b exp=%b", idx, got, t.exp);
        end
        if (sv4 && srdy4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL sb4 unexpected bit got=%b exp=none", so4);
            end else begin
                b = q4.pop_front();
                if (so4 !== b) begin
                    failures++;
                    $display("FAIL sb4 bit got=%b exp=%b", so4, b);
                end
            end
        end
        if (lv4 && lr4) begin
            for (int i = 0; i < 4; i++)
                q4.push_back(lsb4 ? pin4[i] : pin4[3-i]);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    initial begin
        logic [63:0] blk;
        logic        b;

        clear_b = 1'b0;
        lv4 = 1'b0; pin4 = '0; lsb4 = 1'b0; srdy4 = 1'b1;
        lv64 = 1'b0; pin64 = '0; lsb64 = 1'b0; srdy64 = 1'b1;

        // 1: MSB-first 1011
        vecs.push_back(mk(1, 4'b1011, 0, 1,  1, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 0, 0, 2'd2));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 1, 1, 0, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 0, 0, 0, 0, 2'd0));
        // 2: LSB-first 1011
        vecs.push_back(mk(1, 4'b1011, 1, 1,  1, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd2));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 1, 1, 0, 1, 2'd3));
        // 3: backpressure on the second bit for three cycles
        vecs.push_back(mk(1, 4'b1011, 0, 1,  1, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 0,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 0,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 0,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 0, 0, 2'd2));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 1, 1, 0, 1, 2'd3));
        // 4: back-to-back 1011 then 0110, source holding load_valid
        vecs.push_back(mk(1, 4'b1011, 0, 1,  1, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 4'b0110, 0, 1,  0, 1, 1, 1, 0, 2'd0));
        vecs.push_back(mk(1, 4'b0110, 0, 1,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(1, 4'b0110, 0, 1,  0, 1, 1, 0, 0, 2'd2));
        vecs.push_back(mk(1, 4'b0110, 0, 1,  1, 1, 1, 0, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 0, 0, 2'd2));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 0, 1, 0, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 0, 0, 0, 0, 2'd0));
        // stall on the last bit: load_ready stays low and a load is ignored
        vecs.push_back(mk(1, 4'b0001, 1, 1,  1, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 1, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd2));
        vecs.push_back(mk(1, 4'b1111, 0, 0,  0, 0, 1, 0, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 0, 1, 0, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 0, 1,  1, 0, 0, 0, 0, 2'd0));

        // Reset state, sampled while clear_b is held low
        #3;
        chk("reset_dut4", {lr4, so4, sv4, fs4, fe4, bz4, cnt4}, 8'b0);
        chk("reset_dut64", {lr64, so64, sv64, fs64, fe64, bz64, 2'b00}, 8'b0);
        chk("reset_cnt64", {2'b00, cnt64}, 8'b0);
        repeat (2) @(negedge clk);
        clear_b = 1'b1;
        #1;
        chk("post_reset", {lr4, sv4, bz4, 5'b0}, 8'b1000_0000);

        for (int i = 0; i < vecs.size(); i++)
            step4(vecs[i], i);

        // 5: asynchronous reset in the middle of a frame
        step4(mk(1, 4'b1011, 0, 1,  1, 0, 0, 0, 0, 2'd0), 100);
        step4(mk(0, 4'b0000, 0, 1,  0, 1, 1, 1, 0, 2'd0), 101);
        step4(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd1), 102);
        @(negedge clk);
        lv4 = 1'b0; srdy4 = 1'b1;
        #2;
        clear_b = 1'b0;
        #1;
        chk("midframe_reset", {lr4, so4, sv4, fs4, fe4, bz4, cnt4}, 8'b0);
        q4.delete();
        @(negedge clk);
        clear_b = 1'b1;
        #1;
        chk("reset_release", {lr4, sv4, bz4, 5'b0}, 8'b1000_0000);
        step4(mk(1, 4'b0001, 0, 1,  1, 0, 0, 0, 0, 2'd0), 110);
        step4(mk(0, 4'b0000, 0, 1,  0, 0, 1, 1, 0, 2'd0), 111);
        step4(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd1), 112);
        step4(mk(0, 4'b0000, 0, 1,  0, 0, 1, 0, 0, 2'd2), 113);
        step4(mk(0, 4'b0000, 0, 1,  1, 1, 1, 0, 1, 2'd3), 114);
        step4(mk(0, 4'b0000, 0, 1,  1, 0, 0, 0, 0, 2'd0), 115);

        checks++;
        if (q4.size() != 0) begin
            failures++;
            $display("FAIL sb4_drain left=%0d exp=0", q4.size());
        end

        // 6: default 64-bit width, MSB-first
        blk = 64'h0123456789ABCDEF;
        @(negedge clk);
        lv64 = 1'b1; pin64 = blk; lsb64 = 1'b0; srdy64 = 1'b1;
        #1;
        chk("load64_ready", {7'b0, lr64}, 8'b1);
        for (int i = 0; i < 64; i++) q64.push_back(blk[63-i]);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lv64 = 1'b0; pin64 = '1;
            #1;
            b = q64.pop_front();
            checks++;
            if ({so64, sv64, fs64, fe64, cnt64} !==
                {b, 1'b1, (i == 0), (i == 63), 6'(i)}) begin
                failures++;
                $display("FAIL w64 bit%0d got so=%b sv=%b fs=%b fe=%b cnt=%0d exp so=%b cnt=%0d",
                         i, so64, sv64, fs64, fe64, cnt64, b, i);
            end
        end
        @(negedge clk);
        #1;
        chk("w64_done", {6'b0, sv64, lr64}, 8'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
